// File: rtl/hazard_pkg.sv
// Shared latency defaults and counter-width helpers for the hazard scoreboard.
// Used by hazard_sb_entry and hazard_scoreboard_unit.
package hazard_pkg;

  localparam int DEF_REG_ADDR_W  = 4;
  localparam int DEF_NUM_REGS    = 16;
  localparam int DEF_NOFW_LAT    = 2;
  localparam int DEF_LOAD_FW_LAT = 1;
  localparam int DEF_ALU_FW_LAT  = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // clog2(max_lat + 1), never below 1 so an all-zero-latency build still elaborates
  function automatic int cnt_width(input int max_lat);
    int w;
    w = 1;
    while ((1 << w) < (max_lat + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: a down-counter that loads a latency on issue,
// holds on freeze, and reports busy while non-zero.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_freeze,
  output logic             o_busy
);

  logic [CNT_W-1:0] r_cnt;

  // a load wins over the decrement of the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_freeze && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Per-register countdown scoreboard that stalls ID on unresolved sources.
// Optional stall counter (stall_count / perf_clr) enabled by HAZARD_PERF_CNT_EN.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int NOFW_LAT    = DEF_NOFW_LAT,
  parameter int LOAD_FW_LAT = DEF_LOAD_FW_LAT,
  parameter int ALU_FW_LAT  = DEF_ALU_FW_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  two_src,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic                  fw_en,
  input  logic                  freeze,
  input  logic                  flush,
  output logic                  hazard_detected,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  sb_empty
`ifdef HAZARD_PERF_CNT_EN
  ,
  input  logic                  perf_clr,
  output logic [31:0]           stall_count
`endif
);

  localparam int MAX_LAT = max3(NOFW_LAT, LOAD_FW_LAT, ALU_FW_LAT);
  localparam int CNT_W   = cnt_width(MAX_LAT);

  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_load_vec;
  logic [CNT_W-1:0]    w_lat;
  logic                w_hazard;
  logic                w_issue;

  // the instruction's own id_dest is not consulted: only existing writers block it
  assign w_hazard = id_valid && (w_busy[src1] || (two_src && w_busy[src2]));
  assign w_issue  = id_valid && !w_hazard && !freeze && !flush;

  always_comb begin
    w_lat = CNT_W'(ALU_FW_LAT);
    if (!fw_en) begin
      w_lat = CNT_W'(NOFW_LAT);
    end else if (id_mem_r_en) begin
      w_lat = CNT_W'(LOAD_FW_LAT);
    end
  end

  assign w_load_vec = (w_issue && id_wb_en) ? (NUM_REGS'(1) << id_dest) : '0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    hazard_sb_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load_vec[g]),
      .i_load_val (w_lat),
      .i_freeze   (freeze),
      .o_busy     (w_busy[g])
    );
  end

  assign hazard_detected = w_hazard;
  assign busy_mask       = w_busy;
  assign sb_empty        = ~|w_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if (perf_clr) begin
      r_stall_count <= '0;
    end else if (w_hazard && !freeze && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench for hazard_scoreboard_unit: a ready-time reference model
// predicts outputs per cycle; a negedge monitor compares them.
module tb_hazard_scoreboard_unit;

  localparam int LAT_NOFW = 2;
  localparam int LAT_LOAD = 1;
  localparam int LAT_ALU  = 0;

  typedef struct {
    logic       valid;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       two;
    logic [3:0] dest;
    logic       wb;
    logic       ld;
  } instr_t;

  typedef struct {
    logic        haz;
    logic [15:0] mask;
    logic        empty;
    logic [31:0] stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  src1 = '0, src2 = '0, id_dest = '0;
  logic        two_src = 0, id_valid = 0, id_wb_en = 0, id_mem_r_en = 0;
  logic        fw_en = 0, freeze = 0, flush = 0;
  logic        hazard_detected;
  logic [15:0] busy_mask;
  logic        sb_empty;
`ifdef HAZARD_PERF_CNT_EN
  logic        perf_clr = 0;
  logic [31:0] stall_count;
`endif

  hazard_scoreboard_unit dut (
    .clk             (clk),
    .rst             (rst),
    .src1            (src1),
    .src2            (src2),
    .two_src         (two_src),
    .id_valid        (id_valid),
    .id_dest         (id_dest),
    .id_wb_en        (id_wb_en),
    .id_mem_r_en     (id_mem_r_en),
    .fw_en           (fw_en),
    .freeze          (freeze),
    .flush           (flush),
    .hazard_detected (hazard_detected),
    .busy_mask       (busy_mask),
    .sb_empty        (sb_empty)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_clr        (perf_clr),
    .stall_count     (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // model: a register is readable once the count of unfrozen edges reaches ready_at
  int unsigned now = 0;
  int unsigned ready_at [16];
  int unsigned m_stall = 0;
  exp_t expq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic m_busy(input logic [3:0] r);
    return now < ready_at[r];
  endfunction

  function automatic logic [15:0] m_mask();
    logic [15:0] m;
    for (int r = 0; r < 16; r++) m[r] = m_busy(4'(r));
    return m;
  endfunction

  function automatic void m_reset();
    now = 0;
    m_stall = 0;
    for (int r = 0; r < 16; r++) ready_at[r] = 0;
  endfunction

  function automatic instr_t mk(input logic v, input int s1, input int s2, input logic two,
                                input int d, input logic wb, input logic ld);
    instr_t i;
    i.valid = v; i.s1 = 4'(s1); i.s2 = 4'(s2); i.two = two;
    i.dest = 4'(d); i.wb = wb; i.ld = ld;
    return i;
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("hazard", 32'(hazard_detected), 32'(e.haz));
      chk("busy_mask", 32'(busy_mask), 32'(e.mask));
      chk("sb_empty", 32'(sb_empty), 32'(e.empty));
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_count", stall_count, e.stall);
`endif
    end
  end

  // drives one cycle from posedge+1, queues the prediction, advances the model at the edge
  task automatic step(input instr_t in, input logic frz, input logic fl, output logic dut_haz);
    exp_t e;
    logic eh, iss, clr;
    int lat;
    id_valid = in.valid; src1 = in.s1; src2 = in.s2; two_src = in.two;
    id_dest = in.dest; id_wb_en = in.wb; id_mem_r_en = in.ld;
    freeze = frz; flush = fl;
    clr = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    clr = perf_clr;
`endif
    eh = in.valid && (m_busy(in.s1) || (in.two && m_busy(in.s2)));
    e.haz = eh; e.mask = m_mask(); e.empty = (m_mask() == '0); e.stall = m_stall;
    expq.push_back(e);
    iss = in.valid && !eh && !frz && !fl;
    lat = !fw_en ? LAT_NOFW : (in.ld ? LAT_LOAD : LAT_ALU);
    #1 dut_haz = hazard_detected;
    @(posedge clk);
    if (iss && in.wb) ready_at[in.dest] = now + 1 + lat;
    if (!frz) now++;
    if (clr) m_stall = 0;
    else if (eh && !frz && m_stall != 32'hFFFF_FFFF) m_stall++;
    #1;
  endtask

  task automatic idle();
    logic h;
    step(mk(0, 0, 0, 0, 0, 0, 0), 0, 0, h);
  endtask

  task automatic set_fw(input logic v);
    if (v != fw_en) begin
      for (int i = 0; i < 8 && m_mask() != '0; i++) idle();
      assert (sb_empty) else $error("fw_en changed while scoreboard busy");
      fw_en = v;
    end
  endtask

  task automatic run_until_issue(input instr_t in, input int max, output int stalls);
    logic h;
    logic done;
    stalls = 0;
    done = 0;
    for (int i = 0; i < max && !done; i++) begin
      step(in, 0, 0, h);
      if (!h) done = 1;
      else stalls++;
    end
    if (!done) chk("issue_timeout", 32'(stalls), 32'(max + 1));
  endtask

  initial begin
    int st;
    logic h;
    m_reset();
    id_valid = 1; src1 = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hazard", 32'(hazard_detected), 32'd0);
    chk("rst_mask", 32'(busy_mask), 32'd0);
    chk("rst_empty", 32'(sb_empty), 32'd1);
    rst = 1;

    // no forwarding: ALU result readable after 2 stall cycles
    step(mk(1, 0, 0, 0, 3, 1, 0), 0, 0, h);
    run_until_issue(mk(1, 3, 0, 0, 8, 0, 0), 8, st);
    chk("nofw_stalls", 32'(st), 32'd2);

    // forwarding: load-use costs one cycle on src2, none for an unrelated source
    set_fw(1);
    step(mk(1, 0, 0, 0, 5, 1, 1), 0, 0, h);
    run_until_issue(mk(1, 1, 5, 1, 8, 1, 0), 8, st);
    chk("load_use_stalls", 32'(st), 32'd1);
    step(mk(1, 0, 0, 0, 5, 1, 1), 0, 0, h);
    run_until_issue(mk(1, 2, 5, 0, 8, 1, 0), 8, st);
    chk("no_src2_stalls", 32'(st), 32'd0);

    // freeze holds the load counter; release one cycle after freeze drops
    idle();
    step(mk(1, 0, 0, 0, 5, 1, 1), 0, 0, h);
    for (int i = 0; i < 3; i++) begin
      step(mk(1, 5, 0, 0, 6, 1, 0), 1, 0, h);
      chk("freeze_hazard", 32'(h), 32'd1);
      chk("freeze_busy5", 32'(busy_mask[5]), 32'd1);
    end
    run_until_issue(mk(1, 5, 0, 0, 6, 1, 0), 8, st);
    chk("after_freeze_stalls", 32'(st), 32'd1);

    // youngest writer reloads R7
    set_fw(0);
    step(mk(1, 0, 0, 0, 7, 1, 0), 0, 0, h);
    step(mk(1, 1, 0, 0, 7, 1, 0), 0, 0, h);
    chk("overwrite_issue", 32'(h), 32'd0);
    run_until_issue(mk(1, 7, 0, 0, 8, 0, 0), 8, st);
    chk("overwrite_stalls", 32'(st), 32'd2);

    // flush with a hazard present must not load the destination
    idle(); idle();
    step(mk(1, 0, 0, 0, 3, 1, 0), 0, 0, h);
    step(mk(1, 3, 0, 0, 9, 1, 0), 0, 1, h);
    chk("flush_hazard", 32'(h), 32'd1);
    chk("flush_no_load9", 32'(busy_mask[9]), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    perf_clr = 1;
    idle();
    perf_clr = 0;
    chk("perf_clr", stall_count, 32'd0);
`endif

    // asynchronous reset while R3 holds 2
    step(mk(1, 0, 0, 0, 3, 1, 0), 0, 0, h);
    id_valid = 1; src1 = 4'd3;
    rst = 0;
    #1;
    chk("midrst_hazard", 32'(hazard_detected), 32'd0);
    chk("midrst_mask", 32'(busy_mask), 32'd0);
    chk("midrst_empty", 32'(sb_empty), 32'd1);
    m_reset();
    @(posedge clk);
    #1 rst = 1;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      instr_t r;
      if ($urandom_range(0, 39) == 0) set_fw(~fw_en);
`ifdef HAZARD_PERF_CNT_EN
      perf_clr = ($urandom_range(0, 29) == 0);
`endif
      r = mk($urandom_range(0, 5) != 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
             $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      step(r, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, h);
    end
`ifdef HAZARD_PERF_CNT_EN
    perf_clr = 0;
`endif
    idle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
